// File: rtl/hdmi_link_sequencer.sv
// hdmi_link_sequencer: hot-plug driven HDMI sink bring-up over I2C (retimer script, SCDC setup, bounded NACK retry).
// Define HDMI_LINK_SCDC_POLL_EN to poll SCDC scrambler status while running and re-apply the TMDS config on lock loss.
module hdmi_link_sequencer #(
  parameter int CLOCK_FREQUENCY = 0,
  parameter int SETTLE_DIVIDER = 10,
  parameter int POLL_DIVIDER = 4,
  parameter int SCRIPT_DEPTH = 9,
  parameter logic [6:0] SCRIPT_ADDRESS = 7'h5E,
  parameter int MAX_RETRIES = 3,
  localparam int IW = $clog2(SCRIPT_DEPTH + 1)
) (
  input  logic system_clock,
  input  logic system_reset,
  input  logic hpd,
  input  logic scrambler_enable,
  input  logic tmds_bit_clock_ratio,
  output logic [IW-1:0] script_index,
  input  logic [15:0] script_data,
  output logic i2c_ready,
  output logic [6:0] i2c_address,
  output logic i2c_rw,
  output logic [7:0] i2c_register,
  output logic [7:0] i2c_data_write,
  input  logic i2c_valid,
  input  logic i2c_nack,
  input  logic [7:0] i2c_data_read,
  output logic run,
  output logic fault,
  output logic [3:0] retry_count
);
  localparam logic [2:0] IDLE = 3'd0, SETTLE = 3'd1, SCRIPT = 3'd2, SOURCE_VERSION = 3'd3,
                         TMDS_CONFIG = 3'd4, RUN = 3'd5, POLL = 3'd6, FAULT = 3'd7;
  localparam logic [6:0] SCDC_ADDRESS = 7'h54;
  localparam int SETTLE_CYCLES = CLOCK_FREQUENCY / SETTLE_DIVIDER;
  localparam int POLL_CYCLES = CLOCK_FREQUENCY / POLL_DIVIDER;
  // A zero quotient clamps to a one-cycle wait rather than wrapping to 2^32-1
  localparam logic [31:0] SETTLE_RELOAD = SETTLE_CYCLES > 0 ? 32'(SETTLE_CYCLES - 1) : 32'd0;
  localparam logic [31:0] POLL_RELOAD = POLL_CYCLES > 0 ? 32'(POLL_CYCLES - 1) : 32'd0;
  logic [2:0] state;
  logic [31:0] settle_count;
  logic ack, nack, nack_abort, poll_due, unused_bits;
  logic [3:0] retry_next;
  logic [7:0] tmds_config;
  assign ack = i2c_valid & ~i2c_nack;
  assign nack = i2c_valid & i2c_nack;
  assign retry_next = retry_count + 4'd1;
  assign tmds_config = {6'b0, tmds_bit_clock_ratio, scrambler_enable};
  // An HDMI 1.4 sink NACKs the SCDC version write; that is only a failure when SCDC features are wanted
  assign nack_abort = nack & (state == SCRIPT || state == TMDS_CONFIG || state == POLL ||
                              (state == SOURCE_VERSION && (scrambler_enable | tmds_bit_clock_ratio)));
  assign unused_bits = ^{i2c_data_read, POLL_RELOAD};
`ifdef HDMI_LINK_SCDC_POLL_EN
  logic [31:0] poll_count;
  always_ff @(posedge system_clock)
    if (system_reset || state != RUN) poll_count <= POLL_RELOAD;
    else if (scrambler_enable && poll_count != 32'd0) poll_count <= poll_count - 32'd1;
  assign poll_due = scrambler_enable && poll_count == 32'd0;
`else
  assign poll_due = 1'b0;
`endif
  always_ff @(posedge system_clock)
    if (system_reset) begin
      state <= IDLE;
      settle_count <= '0;
      script_index <= '0;
      i2c_ready <= 1'b0;
      i2c_address <= '0;
      i2c_rw <= 1'b0;
      i2c_register <= '0;
      i2c_data_write <= '0;
      run <= 1'b0;
      fault <= 1'b0;
      retry_count <= '0;
    end else if (!hpd && state != IDLE) begin
      state <= IDLE;
      i2c_ready <= 1'b0;
      run <= 1'b0;
      fault <= 1'b0;
      retry_count <= '0;
    end else if (nack_abort) begin
      i2c_ready <= 1'b0;
      run <= 1'b0;
      retry_count <= retry_next;
      if (retry_next == 4'(MAX_RETRIES)) begin
        state <= FAULT;
        fault <= 1'b1;
      end else begin
        state <= SETTLE;
        settle_count <= SETTLE_RELOAD;
        script_index <= '0;
      end
    end else
      case (state)
        IDLE:
          if (hpd) begin
            state <= SETTLE;
            settle_count <= SETTLE_RELOAD;
            script_index <= '0;
          end
        SETTLE:
          if (settle_count != 32'd0) settle_count <= settle_count - 32'd1;
          else begin
            {i2c_register, i2c_data_write} <= script_data;
            i2c_address <= SCRIPT_ADDRESS;
            i2c_rw <= 1'b0;
            script_index <= IW'(1);
            i2c_ready <= 1'b1;
            state <= SCRIPT;
          end
        SCRIPT:
          if (ack && script_index < IW'(SCRIPT_DEPTH)) begin
            {i2c_register, i2c_data_write} <= script_data;
            script_index <= script_index + IW'(1);
          end else if (ack) begin
            i2c_address <= SCDC_ADDRESS;
            {i2c_register, i2c_data_write} <= 16'h0201;
            state <= SOURCE_VERSION;
          end
        SOURCE_VERSION:
          if (ack) begin
            {i2c_register, i2c_data_write} <= {8'h20, tmds_config};
            state <= TMDS_CONFIG;
          end else if (nack) begin
            i2c_ready <= 1'b0;
            run <= 1'b1;
            state <= RUN;
          end
        TMDS_CONFIG:
          if (ack) begin
            i2c_ready <= 1'b0;
            retry_count <= '0;
            run <= 1'b1;
            state <= RUN;
          end
        RUN:
          if (poll_due) begin
            i2c_address <= SCDC_ADDRESS;
            i2c_rw <= 1'b1;
            {i2c_register, i2c_data_write} <= 16'h2100;
            i2c_ready <= 1'b1;
            state <= POLL;
          end
        POLL:
          if (ack && i2c_data_read[0]) begin
            i2c_ready <= 1'b0;
            state <= RUN;
          end else if (ack) begin
            run <= 1'b0;
            i2c_rw <= 1'b0;
            {i2c_register, i2c_data_write} <= {8'h20, tmds_config};
            state <= TMDS_CONFIG;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// tb_hdmi_link_sequencer: directed scenarios; expected I2C requests are queued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_hdmi_link_sequencer;
  typedef struct packed {logic [6:0] address; logic rw; logic [7:0] rg; logic [7:0] data;} req_t;
  logic system_clock = 1'b0, system_reset = 1'b1, hpd = 1'b1;
  logic scrambler_enable = 1'b1, tmds_bit_clock_ratio = 1'b1;
  logic [1:0] script_index;
  logic [15:0] script_data;
  logic i2c_ready, i2c_rw, run, fault;
  logic [6:0] i2c_address;
  logic [7:0] i2c_register, i2c_data_write;
  logic i2c_valid = 1'b0, i2c_nack = 1'b0;
  logic [7:0] i2c_data_read = 8'h00;
  logic [3:0] retry_count;
  logic prev_ready = 1'b0;
  req_t exp_q[$];
  int n_tests = 0, n_fail = 0;

  hdmi_link_sequencer #(.CLOCK_FREQUENCY(100), .SCRIPT_DEPTH(3)) dut (
    .system_clock(system_clock), .system_reset(system_reset), .hpd(hpd),
    .scrambler_enable(scrambler_enable), .tmds_bit_clock_ratio(tmds_bit_clock_ratio),
    .script_index(script_index), .script_data(script_data),
    .i2c_ready(i2c_ready), .i2c_address(i2c_address), .i2c_rw(i2c_rw),
    .i2c_register(i2c_register), .i2c_data_write(i2c_data_write),
    .i2c_valid(i2c_valid), .i2c_nack(i2c_nack), .i2c_data_read(i2c_data_read),
    .run(run), .fault(fault), .retry_count(retry_count)
  );

  always #5 system_clock = ~system_clock;

  always_comb script_data = script_index == 2'd0 ? 16'hA101 : script_index == 2'd1 ? 16'hB202 :
                            script_index == 2'd2 ? 16'hC303 : 16'h0000;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back({a, rw, r, d});
  endtask

  // Answers the pending request one cycle after it is seen, optionally dropping hpd on the same cycle
  task automatic serve(input logic nack, input logic [7:0] rd, input logic drop_hpd);
    for (int i = 0; i < 300 && !i2c_ready; i++) @(negedge system_clock);
    check("request_timeout", 32'(i2c_ready), 32'd1);
    @(negedge system_clock);
    i2c_valid = 1'b1;
    i2c_nack = nack;
    i2c_data_read = rd;
    if (drop_hpd) hpd = 1'b0;
    @(negedge system_clock);
    i2c_valid = 1'b0;
    i2c_nack = 1'b0;
    i2c_data_read = 8'h00;
  endtask

  // A request is new when ready rises or stays high across a completion
  initial begin
    req_t got, want;
    forever begin
      @(posedge system_clock);
      #1;
      if (i2c_ready && (!prev_ready || i2c_valid)) begin
        got = {i2c_address, i2c_rw, i2c_register, i2c_data_write};
        if (exp_q.size() == 0) check("unexpected_request", 32'(got), 32'hFFFFFFFF);
        else begin
          want = exp_q.pop_front();
          check("request", 32'(got), 32'(want));
        end
      end
      prev_ready = i2c_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    push(7'h5E, 1'b0, 8'hA1, 8'h01);
    push(7'h5E, 1'b0, 8'hB2, 8'h02);
    push(7'h5E, 1'b0, 8'hC3, 8'h03);
    push(7'h54, 1'b0, 8'h02, 8'h01);
    push(7'h54, 1'b0, 8'h20, 8'h03);
    repeat (3) @(negedge system_clock);
    check("reset_request", 32'({i2c_ready, i2c_address, i2c_rw, i2c_register, i2c_data_write}), 32'd0);
    check("reset_status", 32'({run, fault, retry_count, script_index}), 32'd0);
    system_reset = 1'b0;
    repeat (10) @(negedge system_clock);
    check("ready_before_settle", 32'(i2c_ready), 32'd0);
    @(negedge system_clock);
    check("first_ready", 32'(i2c_ready), 32'd1);
    check("first_index", 32'(script_index), 32'd1);
    repeat (4) serve(1'b0, 8'h00, 1'b0);
    check("run_before_final_ack", 32'(run), 32'd0);
    serve(1'b0, 8'h00, 1'b0);
    check("run_after_final_ack", 32'(run), 32'd1);
    check("ready_in_run", 32'(i2c_ready), 32'd0);
    check("retry_in_run", 32'(retry_count), 32'd0);
`ifndef HDMI_LINK_SCDC_POLL_EN
    repeat (40) @(negedge system_clock);
    check("run_hold", 32'(run), 32'd1);
`endif
    hpd = 1'b0;
    @(negedge system_clock);
    check("run_falls", 32'(run), 32'd0);

    scrambler_enable = 1'b0;
    tmds_bit_clock_ratio = 1'b0;
    push(7'h5E, 1'b0, 8'hA1, 8'h01);
    push(7'h5E, 1'b0, 8'hB2, 8'h02);
    push(7'h5E, 1'b0, 8'hC3, 8'h03);
    push(7'h54, 1'b0, 8'h02, 8'h01);
    hpd = 1'b1;
    repeat (3) serve(1'b0, 8'h00, 1'b0);
    serve(1'b1, 8'h00, 1'b0);
    check("hdmi14_run", 32'(run), 32'd1);
    check("hdmi14_retry", 32'(retry_count), 32'd0);
    repeat (20) @(negedge system_clock);
    check("no_tmds_write", 32'(i2c_ready), 32'd0);
    hpd = 1'b0;
    @(negedge system_clock);

    scrambler_enable = 1'b1;
    tmds_bit_clock_ratio = 1'b1;
    hpd = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      push(7'h5E, 1'b0, 8'hA1, 8'h01);
      push(7'h5E, 1'b0, 8'hB2, 8'h02);
      serve(1'b0, 8'h00, 1'b0);
      serve(1'b1, 8'h00, 1'b0);
      check("retry_count", 32'(retry_count), 32'(k));
    end
    check("fault_set", 32'(fault), 32'd1);
    check("fault_ready", 32'(i2c_ready), 32'd0);
    repeat (20) @(negedge system_clock);
    check("fault_sticky", 32'({fault, i2c_ready}), 32'b10);
    hpd = 1'b0;
    @(negedge system_clock);
    check("fault_cleared", 32'({fault, retry_count}), 32'd0);

    push(7'h5E, 1'b0, 8'hA1, 8'h01);
    push(7'h5E, 1'b0, 8'hB2, 8'h02);
    hpd = 1'b1;
    serve(1'b0, 8'h00, 1'b0);
    serve(1'b0, 8'h00, 1'b1);
    check("hpd_loss_ready", 32'(i2c_ready), 32'd0);
    check("hpd_loss_index", 32'(script_index), 32'd2);
    check("hpd_loss_run", 32'(run), 32'd0);
    repeat (5) @(negedge system_clock);

`ifdef HDMI_LINK_SCDC_POLL_EN
    push(7'h5E, 1'b0, 8'hA1, 8'h01);
    push(7'h5E, 1'b0, 8'hB2, 8'h02);
    push(7'h5E, 1'b0, 8'hC3, 8'h03);
    push(7'h54, 1'b0, 8'h02, 8'h01);
    push(7'h54, 1'b0, 8'h20, 8'h03);
    push(7'h54, 1'b1, 8'h21, 8'h00);
    push(7'h54, 1'b0, 8'h20, 8'h03);
    push(7'h54, 1'b1, 8'h21, 8'h00);
    hpd = 1'b1;
    repeat (5) serve(1'b0, 8'h00, 1'b0);
    check("poll_run_up", 32'(run), 32'd1);
    serve(1'b0, 8'h00, 1'b0);
    check("lock_lost_run", 32'(run), 32'd0);
    check("lock_lost_rewrite", 32'(i2c_ready), 32'd1);
    serve(1'b0, 8'h00, 1'b0);
    check("relock_run", 32'(run), 32'd1);
    serve(1'b0, 8'h01, 1'b0);
    check("locked_run", 32'({run, i2c_ready}), 32'b10);
    repeat (10) @(negedge system_clock);
    check("no_write_when_locked", 32'(i2c_ready), 32'd0);
    hpd = 1'b0;
    @(negedge system_clock);
`endif

    repeat (3) @(negedge system_clock);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
